id_ex_stage_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection. Captures decoded operands
//  and control from ID and presents the *_E signals that EX operand muxes and the forwarding unit

---
 rtl/riscv_pipe_pkg.sv | 39 +++
 rtl/load_use_detector.sv | 22 ++
 rtl/id_ex_stage_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths, control-bundle bit layout,
// ALU operation encodings and the all-zero NOP control word.
package riscv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 11;

    // Control bundle layout, MSB first:
    // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, ALUOp[3:0]}
    localparam int CTRL_REGWRITE  = 10;
    localparam int CTRL_MEMREAD   = 9;
    localparam int CTRL_MEMWRITE  = 8;
    localparam int CTRL_MEMTOREG  = 7;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_JUMP      = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Extract MemRead from a control word.
    function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detection: a valid load in E whose non-x0 destination is
// read by the valid instruction in D.
module load_use_detector (
    input  logic       valid_e_i,
    input  logic       memread_e_i,
    input  logic [4:0] waddr_e_i,
    input  logic       valid_d_i,
    input  logic       uses1_d_i,
    input  logic       uses2_d_i,
    input  logic [4:0] raddr1_d_i,
    input  logic [4:0] raddr2_d_i,
    output logic       hazard_o
);

    logic match1, match2;

    assign match1   = uses1_d_i && (raddr1_d_i == waddr_e_i);
    assign match2   = uses2_d_i && (raddr2_d_i == waddr_e_i);
    assign hazard_o = valid_e_i && memread_e_i && (waddr_e_i != 5'd0) &&
                      valid_d_i && (match1 || match2);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush bubbles and
// memory-stall hold. Optional perf counters built when PERF_CNT_EN is defined.
module id_ex_stage_reg #(
    parameter int XLEN   = riscv_pipe_pkg::XLEN,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_D,
    input  logic [XLEN-1:0]   PC_D,
    input  logic [XLEN-1:0]   Rdata1_D,
    input  logic [XLEN-1:0]   Rdata2_D,
    input  logic [XLEN-1:0]   Imm_D,
    input  logic [4:0]        Raddr1_D,
    input  logic [4:0]        Raddr2_D,
    input  logic              Uses1_D,
    input  logic              Uses2_D,
    input  logic [4:0]        Waddr_D,
    input  logic [CTRL_W-1:0] ctrl_D,
    input  logic              flush_E,
    input  logic              mem_stall,
    output logic              valid_E,
    output logic [XLEN-1:0]   PC_E,
    output logic [XLEN-1:0]   Rdata1_E,
    output logic [XLEN-1:0]   Rdata2_E,
    output logic [XLEN-1:0]   Imm_E,
    output logic [4:0]        Raddr1_E,
    output logic [4:0]        Raddr2_E,
    output logic [4:0]        Waddr_E,
    output logic [CTRL_W-1:0] ctrl_E,
    output logic              stall_FD,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import riscv_pipe_pkg::*;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2_q, rdata2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        raddr1_q, raddr1_d;
    logic [4:0]        raddr2_q, raddr2_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hazard;

    load_use_detector u_lud (
        .valid_e_i   (valid_q),
        .memread_e_i (ctrl_q[CTRL_MEMREAD]),
        .waddr_e_i   (waddr_q),
        .valid_d_i   (valid_D),
        .uses1_d_i   (Uses1_D),
        .uses2_d_i   (Uses2_D),
        .raddr1_d_i  (Raddr1_D),
        .raddr2_d_i  (Raddr2_D),
        .hazard_o    (hazard)
    );

    assign stall_FD = mem_stall | hazard;

    // Next-state: hold on mem_stall, bubble on flush/hazard, else load from D.
    // Bubbles clear only valid/control/register indices; data fields keep
    // their last value since nothing consumes them without valid.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        waddr_d  = waddr_q;
        ctrl_d   = ctrl_q;
        if (mem_stall) begin
            // hold everything
        end else if (flush_E || hazard) begin
            valid_d  = 1'b0;
            ctrl_d   = CTRL_NOP;
            raddr1_d = 5'd0;
            raddr2_d = 5'd0;
            waddr_d  = 5'd0;
        end else begin
            valid_d  = valid_D;
            pc_d     = PC_D;
            rdata1_d = Rdata1_D;
            rdata2_d = Rdata2_D;
            imm_d    = Imm_D;
            raddr1_d = Raddr1_D;
            raddr2_d = Raddr2_D;
            waddr_d  = Waddr_D;
            ctrl_d   = valid_D ? ctrl_D : CTRL_NOP;
        end
    end

    // E-stage register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            waddr_q  <= '0;
            ctrl_q   <= CTRL_NOP;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            waddr_q  <= waddr_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign valid_E  = valid_q;
    assign PC_E     = pc_q;
    assign Rdata1_E = rdata1_q;
    assign Rdata2_E = rdata2_q;
    assign Imm_E    = imm_q;
    assign Raddr1_E = raddr1_q;
    assign Raddr2_E = raddr2_q;
    assign Waddr_E  = waddr_q;
    assign ctrl_E   = ctrl_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters; a flush or mem_stall masks the stall event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard && !mem_stall && !flush_E && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_E && !mem_stall && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
